// File: rtl/trap_seq_pkg.sv
// Shared constants, CSR addresses, mstatus bit positions and FSM encodings
// for the machine-mode trap/mret sequencer.
package trap_seq_pkg;

    localparam int XLEN      = 32;
    localparam int HART_ID_W = 2;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LSB  = 11;
    localparam int MSTATUS_MPP_MSB  = 12;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_FLUSH        = 3'd1,
        ST_WR_MEPC      = 3'd2,
        ST_WR_MCAUSE    = 3'd3,
        ST_WR_MSTATUS   = 3'd4,
        ST_MRET_MSTATUS = 3'd5,
        ST_REDIRECT     = 3'd6
    } state_t;

endpackage

// File: rtl/trap_seq.sv
// Sequences M-mode trap entry (drain, write mepc/mcause/mstatus, redirect)
// and mret return (drain, restore mstatus, redirect to mepc).
module trap_seq
    import trap_seq_pkg::*;
#(
    parameter int CSR_ADDR_W  = 12,
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  take_trap,
    input  logic [HART_ID_W-1:0]  trap_hart_id,
    input  logic [XLEN-1:0]       trap_vector,
    input  logic [XLEN-1:0]       trap_mepc,
    input  logic [XLEN-1:0]       trap_mcause,
    input  logic                  mret_req,
    input  logic [HART_ID_W-1:0]  mret_hart_id,
    input  logic [XLEN-1:0]       mepc_in,
    input  logic [XLEN-1:0]       mstatus_in,
    output logic                  flush_req,
    input  logic                  flush_ack,
    output logic                  csr_we,
    output logic [CSR_ADDR_W-1:0] csr_waddr,
    output logic [XLEN-1:0]       csr_wdata,
    output logic                  redirect_valid,
    output logic [XLEN-1:0]       redirect_pc,
    output logic [HART_ID_W-1:0]  redirect_hart,
    output logic                  trap_ack,
    output logic                  mret_ack,
    output logic                  busy
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    state_t                 state;
    logic                   is_trap_q;
    logic [HART_ID_W-1:0]   hart_q;
    logic [XLEN-1:0]        mepc_q;
    logic [XLEN-1:0]        mcause_q;
    logic [XLEN-1:0]        target_q;
    logic [XLEN-1:0]        trap_mstatus;
    logic [XLEN-1:0]        mret_mstatus;

    // Vectored mode applies only to interrupts; MODE 2/3 fall back to direct.
    function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] vec,
                                                    input logic [XLEN-1:0] cause);
        logic [XLEN-1:0] base;
        base = vec & ALIGN_MASK;
        if (VECTORED_EN && vec[1:0] == 2'b01 && cause[XLEN-1])
            return base + (XLEN'(cause[XLEN-2:0]) << 2);
        return base;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            is_trap_q <= 1'b0;
            hart_q    <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
            target_q  <= '0;
            flush_req <= 1'b0;
            trap_ack  <= 1'b0;
            mret_ack  <= 1'b0;
        end else begin
            trap_ack <= 1'b0;
            mret_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    flush_req <= 1'b0;
                    if (take_trap) begin
                        is_trap_q <= 1'b1;
                        hart_q    <= trap_hart_id;
                        mepc_q    <= trap_mepc & ALIGN_MASK;
                        mcause_q  <= trap_mcause;
                        target_q  <= trap_target(trap_vector, trap_mcause);
                        trap_ack  <= 1'b1;
                        state     <= ST_FLUSH;
                    end else if (mret_req) begin
                        is_trap_q <= 1'b0;
                        hart_q    <= mret_hart_id;
                        target_q  <= mepc_in & ALIGN_MASK;
                        mret_ack  <= 1'b1;
                        state     <= ST_FLUSH;
                    end
                end
                // flush_req rises the cycle after the ack, so an ack is only honoured once requested.
                ST_FLUSH: begin
                    if (flush_req && flush_ack) begin
                        flush_req <= 1'b0;
                        state     <= is_trap_q ? ST_WR_MEPC : ST_MRET_MSTATUS;
                    end else begin
                        flush_req <= 1'b1;
                    end
                end
                ST_WR_MEPC:      state <= ST_WR_MCAUSE;
                ST_WR_MCAUSE:    state <= ST_WR_MSTATUS;
                ST_WR_MSTATUS:   state <= ST_REDIRECT;
                ST_MRET_MSTATUS: state <= ST_REDIRECT;
                ST_REDIRECT:     state <= ST_IDLE;
                default:         state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        trap_mstatus = mstatus_in;
        trap_mstatus[MSTATUS_MPIE_BIT] = mstatus_in[MSTATUS_MIE_BIT];
        trap_mstatus[MSTATUS_MIE_BIT]  = 1'b0;
        trap_mstatus[MSTATUS_MPP_MSB:MSTATUS_MPP_LSB] = 2'b11;

        mret_mstatus = mstatus_in;
        mret_mstatus[MSTATUS_MIE_BIT]  = mstatus_in[MSTATUS_MPIE_BIT];
        mret_mstatus[MSTATUS_MPIE_BIT] = 1'b1;
        mret_mstatus[MSTATUS_MPP_MSB:MSTATUS_MPP_LSB] = 2'b11;
    end

    // mstatus writes use the live mstatus_in of the write cycle, so data is decoded, not pre-registered.
    always_comb begin
        csr_we         = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        redirect_hart  = '0;
        case (state)
            ST_WR_MEPC: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_ADDR_W'(CSR_MEPC);
                csr_wdata = mepc_q;
            end
            ST_WR_MCAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_ADDR_W'(CSR_MCAUSE);
                csr_wdata = mcause_q;
            end
            ST_WR_MSTATUS: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_ADDR_W'(CSR_MSTATUS);
                csr_wdata = trap_mstatus;
            end
            ST_MRET_MSTATUS: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_ADDR_W'(CSR_MSTATUS);
                csr_wdata = mret_mstatus;
            end
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
                redirect_hart  = hart_q;
            end
            default: ;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_trap_seq.sv
// Directed self-checking bench for trap_seq: trap entry, vectored target,
// mret, arbitration, flush gating and mid-sequence reset.
module tb_trap_seq;
    import trap_seq_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 take_trap = 1'b0;
    logic [HART_ID_W-1:0] trap_hart_id = '0;
    logic [XLEN-1:0]      trap_vector = '0;
    logic [XLEN-1:0]      trap_mepc = '0;
    logic [XLEN-1:0]      trap_mcause = '0;
    logic                 mret_req = 1'b0;
    logic [HART_ID_W-1:0] mret_hart_id = '0;
    logic [XLEN-1:0]      mepc_in = '0;
    logic [XLEN-1:0]      mstatus_in = '0;
    logic                 flush_ack = 1'b0;

    logic                 flush_req, csr_we, redirect_valid, trap_ack, mret_ack, busy;
    logic [11:0]          csr_waddr;
    logic [XLEN-1:0]      csr_wdata, redirect_pc;
    logic [HART_ID_W-1:0] redirect_hart;

    logic                 nv_flush_req, nv_csr_we, nv_redirect_valid, nv_trap_ack, nv_mret_ack, nv_busy;
    logic [11:0]          nv_csr_waddr;
    logic [XLEN-1:0]      nv_csr_wdata, nv_redirect_pc;
    logic [HART_ID_W-1:0] nv_redirect_hart;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    trap_seq #(.CSR_ADDR_W(12), .VECTORED_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .take_trap(take_trap), .trap_hart_id(trap_hart_id),
        .trap_vector(trap_vector), .trap_mepc(trap_mepc), .trap_mcause(trap_mcause),
        .mret_req(mret_req), .mret_hart_id(mret_hart_id), .mepc_in(mepc_in),
        .mstatus_in(mstatus_in), .flush_req(flush_req), .flush_ack(flush_ack),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_hart(redirect_hart), .trap_ack(trap_ack), .mret_ack(mret_ack), .busy(busy)
    );

    // Direct-only instance sharing all stimulus, to compare the vectored target.
    trap_seq #(.CSR_ADDR_W(12), .VECTORED_EN(1'b0)) dut_nv (
        .clk(clk), .rst_n(rst_n), .take_trap(take_trap), .trap_hart_id(trap_hart_id),
        .trap_vector(trap_vector), .trap_mepc(trap_mepc), .trap_mcause(trap_mcause),
        .mret_req(mret_req), .mret_hart_id(mret_hart_id), .mepc_in(mepc_in),
        .mstatus_in(mstatus_in), .flush_req(nv_flush_req), .flush_ack(flush_ack),
        .csr_we(nv_csr_we), .csr_waddr(nv_csr_waddr), .csr_wdata(nv_csr_wdata),
        .redirect_valid(nv_redirect_valid), .redirect_pc(nv_redirect_pc),
        .redirect_hart(nv_redirect_hart), .trap_ack(nv_trap_ack), .mret_ack(nv_mret_ack),
        .busy(nv_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] vec, input logic [31:0] mepc,
                                 input logic [31:0] cause, input logic [31:0] mstatus,
                                 input logic [1:0] hart);
        trap_vector  = vec;
        trap_mepc    = mepc;
        trap_mcause  = cause;
        mstatus_in   = mstatus;
        trap_hart_id = hart;
    endtask

    // Called in the cycle flush_ack is presented (F); walks F+1..F+5.
    task automatic runTrapTail(input string tag, input logic [31:0] exp_mepc,
                               input logic [31:0] exp_cause, input logic [31:0] exp_mstatus,
                               input logic [31:0] exp_pc, input logic [31:0] exp_pc_nv,
                               input logic [1:0] hart);
        tick();
        flush_ack = 1'b0;
        checkOutput({tag, " mepc we"}, 32'(csr_we), 32'd1);
        checkOutput({tag, " mepc addr"}, 32'(csr_waddr), 32'h341);
        checkOutput({tag, " mepc data"}, csr_wdata, exp_mepc);
        tick();
        checkOutput({tag, " mcause addr"}, 32'(csr_waddr), 32'h342);
        checkOutput({tag, " mcause data"}, csr_wdata, exp_cause);
        tick();
        checkOutput({tag, " mstatus addr"}, 32'(csr_waddr), 32'h300);
        checkOutput({tag, " mstatus data"}, csr_wdata, exp_mstatus);
        tick();
        checkOutput({tag, " redirect valid"}, 32'(redirect_valid), 32'd1);
        checkOutput({tag, " redirect pc"}, redirect_pc, exp_pc);
        checkOutput({tag, " redirect pc direct-only"}, nv_redirect_pc, exp_pc_nv);
        checkOutput({tag, " redirect hart"}, 32'(redirect_hart), 32'(hart));
        checkOutput({tag, " no csr at redirect"}, 32'(csr_we), 32'd0);
        tick();
        checkOutput({tag, " idle after"}, 32'(busy), 32'd0);
        checkOutput({tag, " redirect one cycle"}, 32'(redirect_valid), 32'd0);
    endtask

    task automatic runMretTail(input string tag, input logic [31:0] exp_mstatus,
                               input logic [31:0] exp_pc, input logic [1:0] hart);
        tick();
        flush_ack = 1'b0;
        checkOutput({tag, " mstatus we"}, 32'(csr_we), 32'd1);
        checkOutput({tag, " mstatus addr"}, 32'(csr_waddr), 32'h300);
        checkOutput({tag, " mstatus data"}, csr_wdata, exp_mstatus);
        tick();
        checkOutput({tag, " redirect valid"}, 32'(redirect_valid), 32'd1);
        checkOutput({tag, " redirect pc"}, redirect_pc, exp_pc);
        checkOutput({tag, " redirect hart"}, 32'(redirect_hart), 32'(hart));
        checkOutput({tag, " single csr write"}, 32'(csr_we), 32'd0);
        tick();
        checkOutput({tag, " idle after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int ack_count;
        int flush_count;
        int write_count;
        int stray;

        // Reset state
        tick();
        tick();
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset flush_req", 32'(flush_req), 32'd0);
        checkOutput("reset csr_we", 32'(csr_we), 32'd0);
        checkOutput("reset redirect", 32'(redirect_valid), 32'd0);
        checkOutput("reset trap_ack", 32'(trap_ack), 32'd0);
        #3 rst_n = 1'b1;
        tick();

        // 1: direct trap, flush_ack three cycles after the ack
        $display("[TB] direct trap");
        applyStimulus(32'h0000_0100, 32'h0000_2006, 32'h8000_000B, 32'h0000_0008, 2'd1);
        take_trap = 1'b1;
        tick();
        take_trap = 1'b0;
        checkOutput("t1 trap_ack", 32'(trap_ack), 32'd1);
        checkOutput("t1 busy", 32'(busy), 32'd1);
        checkOutput("t1 flush_req at ack", 32'(flush_req), 32'd0);
        tick();
        checkOutput("t1 flush_req T+1", 32'(flush_req), 32'd1);
        checkOutput("t1 trap_ack pulse", 32'(trap_ack), 32'd0);
        tick();
        tick();
        flush_ack = 1'b1;
        checkOutput("t1 no csr before ack", 32'(csr_we), 32'd0);
        runTrapTail("t1", 32'h0000_2004, 32'h8000_000B, 32'h0000_1880,
                    32'h0000_0100, 32'h0000_0100, 2'd1);

        // 2: vectored interrupt
        $display("[TB] vectored trap");
        applyStimulus(32'h0000_0101, 32'h0000_3000, 32'h8000_000B, 32'h0000_0008, 2'd2);
        take_trap = 1'b1;
        tick();
        take_trap = 1'b0;
        checkOutput("t2 trap_ack", 32'(trap_ack), 32'd1);
        tick();
        flush_ack = 1'b1;
        runTrapTail("t2", 32'h0000_3000, 32'h8000_000B, 32'h0000_1880,
                    32'h0000_012C, 32'h0000_0100, 2'd2);

        // 3: mret
        $display("[TB] mret");
        mstatus_in   = 32'h0000_1880;
        mepc_in      = 32'h0000_2004;
        mret_hart_id = 2'd2;
        mret_req     = 1'b1;
        tick();
        mret_req = 1'b0;
        checkOutput("t3 mret_ack", 32'(mret_ack), 32'd1);
        checkOutput("t3 no trap_ack", 32'(trap_ack), 32'd0);
        checkOutput("t3 busy", 32'(busy), 32'd1);
        tick();
        checkOutput("t3 flush_req", 32'(flush_req), 32'd1);
        checkOutput("t3 mret_ack pulse", 32'(mret_ack), 32'd0);
        flush_ack = 1'b1;
        runMretTail("t3", 32'h0000_1888, 32'h0000_2004, 2'd2);

        // 4: simultaneous requests, trap wins, mret accepted afterwards
        $display("[TB] simultaneous trap and mret");
        applyStimulus(32'h0000_0100, 32'h0000_4008, 32'h0000_0002, 32'h0000_0000, 2'd3);
        mret_hart_id = 2'd1;
        take_trap = 1'b1;
        mret_req  = 1'b1;
        tick();
        take_trap = 1'b0;
        checkOutput("t4 trap_ack", 32'(trap_ack), 32'd1);
        checkOutput("t4 mret_ack squashed", 32'(mret_ack), 32'd0);
        tick();
        flush_ack = 1'b1;
        runTrapTail("t4", 32'h0000_4008, 32'h0000_0002, 32'h0000_1800,
                    32'h0000_0100, 32'h0000_0100, 2'd3);
        checkOutput("t4 mret_ack still 0", 32'(mret_ack), 32'd0);
        tick();
        mret_req = 1'b0;
        checkOutput("t4 mret re-accepted", 32'(mret_ack), 32'd1);
        tick();
        flush_ack = 1'b1;
        runMretTail("t4 mret", 32'h0000_1880, 32'h0000_2004, 2'd1);

        // 5: take_trap held, flush_ack withheld for 20 cycles
        $display("[TB] busy and flush gating");
        applyStimulus(32'h0000_0100, 32'h0000_5000, 32'h0000_0005, 32'h0000_0008, 2'd0);
        take_trap = 1'b1;
        tick();
        checkOutput("t5 trap_ack", 32'(trap_ack), 32'd1);
        ack_count   = 0;
        flush_count = 0;
        write_count = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            flush_count += int'(flush_req);
            write_count += int'(csr_we);
            ack_count   += int'(trap_ack);
        end
        checkOutput("t5 flush_req cycles", 32'(flush_count), 32'd20);
        checkOutput("t5 no early csr write", 32'(write_count), 32'd0);
        flush_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            flush_ack = 1'b0;
            write_count += int'(csr_we);
            ack_count   += int'(trap_ack);
        end
        checkOutput("t5 redirect", 32'(redirect_valid), 32'd1);
        take_trap = 1'b0;
        tick();
        checkOutput("t5 csr writes", 32'(write_count), 32'd3);
        checkOutput("t5 extra trap_ack", 32'(ack_count), 32'd0);
        checkOutput("t5 idle", 32'(busy), 32'd0);

        // 6: reset asserted during WR_MCAUSE
        $display("[TB] reset mid-sequence");
        applyStimulus(32'h0000_0100, 32'h0000_6000, 32'h0000_0007, 32'h0000_0008, 2'd1);
        take_trap = 1'b1;
        tick();
        take_trap = 1'b0;
        tick();
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        tick();
        checkOutput("t6 in WR_MCAUSE", 32'(csr_waddr), 32'h342);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6 async csr_we", 32'(csr_we), 32'd0);
        checkOutput("t6 async csr_waddr", 32'(csr_waddr), 32'd0);
        checkOutput("t6 async csr_wdata", csr_wdata, 32'd0);
        checkOutput("t6 async busy", 32'(busy), 32'd0);
        checkOutput("t6 async redirect_pc", redirect_pc, 32'd0);
        tick();
        tick();
        #3 rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            stray += int'(csr_we) + int'(redirect_valid) + int'(busy);
        end
        checkOutput("t6 nothing after reset", 32'(stray), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
